// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory signals of cache_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the caches/memory side.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one memory port, one at a time.
// Define CACHE_ARB_ROUND_ROBIN_EN to alternate grants under contention instead of D-first.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input logic                 clk,
    input logic                 reset,
    cache_mem_arbiter_if.slave  bus
);
    localparam int unsigned OffsetBits = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OffsetMask = ADDR_WIDTH'((1 << OffsetBits) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIRd,
        StDRd,
        StDWr,
        StRespI,
        StRespD
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
    logic [LINE_WIDTH-1:0] drdata_q, drdata_d;
    logic                  d_req;
    logic                  grant_d;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // High when the D-cache wins the next contended grant.
    logic prefer_d_q, prefer_d_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        d_req    = bus.dcache_read | bus.dcache_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        prefer_d_d = prefer_d_q;
        grant_d    = d_req & (~bus.icache_read | prefer_d_q);
`else
        grant_d    = d_req;
`endif

        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    // A simultaneous read and write is served as a write-back.
                    state_d = bus.dcache_write ? StDWr : StDRd;
                    addr_d  = bus.dcache_address & ~OffsetMask;
                    if (bus.dcache_write) begin
                        wdata_d = bus.dcache_wdata;
                    end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    prefer_d_d = 1'b0;
`endif
                end else if (bus.icache_read) begin
                    state_d = StIRd;
                    addr_d  = bus.icache_address & ~OffsetMask;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    prefer_d_d = 1'b1;
`endif
                end
            end
            StIRd: begin
                if (bus.pmem_resp) begin
                    irdata_d = bus.pmem_rdata;
                    state_d  = StRespI;
                end
            end
            StDRd: begin
                if (bus.pmem_resp) begin
                    drdata_d = bus.pmem_rdata;
                    state_d  = StRespD;
                end
            end
            StDWr: begin
                if (bus.pmem_resp) begin
                    state_d = StRespD;
                end
            end
            StRespI, StRespD: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_d_q <= 1'b1;
        end else begin
            prefer_d_q <= prefer_d_d;
        end
    end
`endif

    // Strobes and pulses decode straight from the state register, so reset clears them in a cycle.
    assign bus.pmem_read    = (state_q == StIRd) || (state_q == StDRd);
    assign bus.pmem_write   = (state_q == StDWr);
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.icache_resp  = (state_q == StRespI);
    assign bus.dcache_resp  = (state_q == StRespD);
    assign bus.icache_rdata = irdata_q;
    assign bus.dcache_rdata = drdata_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised self-checking bench for cache_mem_arbiter against a transaction-level model.
// Follows CACHE_ARB_ROUND_ROBIN_EN when compiled with it.
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: last line returned to each cache and who was granted last.
    logic [127:0] exp_ir;
    logic [127:0] exp_dr;
    bit           last_d;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

    cache_mem_arbiter #(
        .ADDR_WIDTH(16),
        .LINE_WIDTH(128)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Contention rule: fixed D priority, or the cache not served last.
    function automatic bit pick_d_on_contention();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_strobes"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
        check_eq({tag, "_resps"}, {bus.icache_resp, bus.dcache_resp}, 2'b00);
    endtask

    // The grant happens on the next clock edge; requests must already be driven.
    task automatic run_txn(input bit is_i, input bit is_wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int lat, input logic [127:0] rd);
        logic [15:0] exp_addr;
        exp_addr = {addr[15:4], 4'h0};
        for (int c = 0; c < lat; c++) begin
            @(posedge clk); #1;
            check_eq("pmem_read", bus.pmem_read, !is_wr);
            check_eq("pmem_write", bus.pmem_write, is_wr);
            check_eq("pmem_address", bus.pmem_address, exp_addr);
            if (is_wr) check_eq("pmem_wdata", bus.pmem_wdata, wd);
            check_eq("resp_during_txn", {bus.icache_resp, bus.dcache_resp}, 2'b00);
            if (c == lat - 1) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rd;
            end
        end
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = rand128();
        if (!is_wr) begin
            if (is_i) exp_ir = rd;
            else      exp_dr = rd;
        end
        check_eq("strobe_after_resp", {bus.pmem_read, bus.pmem_write}, 2'b00);
        check_eq("icache_resp", bus.icache_resp, is_i);
        check_eq("dcache_resp", bus.dcache_resp, !is_i);
        check_eq("icache_rdata", bus.icache_rdata, exp_ir);
        check_eq("dcache_rdata", bus.dcache_rdata, exp_dr);
        if (is_i) begin
            bus.icache_read = 1'b0;
        end else begin
            bus.dcache_read  = 1'b0;
            bus.dcache_write = 1'b0;
        end
        @(posedge clk); #1;
        check_quiet("dead_cycle");
    endtask

    // dkind[0] = dcache_read, dkind[1] = dcache_write.
    task automatic scenario(input bit want_i, input logic [1:0] dkind, input logic [15:0] ia,
                            input logic [15:0] da, input logic [127:0] wd);
        bit pend_i;
        bit pend_d;
        bit pick_d;
        pend_i = want_i;
        pend_d = (dkind != 2'b00);
        bus.icache_read    = want_i;
        bus.icache_address = ia;
        bus.dcache_read    = dkind[0];
        bus.dcache_write   = dkind[1];
        bus.dcache_address = da;
        bus.dcache_wdata   = wd;
        while (pend_i || pend_d) begin
            pick_d = (pend_i && pend_d) ? pick_d_on_contention() : pend_d;
            last_d = pick_d;
            if (pick_d) begin
                run_txn(1'b0, dkind[1], da, wd, $urandom_range(1, 6), rand128());
                pend_d = 1'b0;
            end else begin
                run_txn(1'b1, 1'b0, ia, '0, $urandom_range(1, 6), rand128());
                pend_i = 1'b0;
            end
        end
    endtask

    task automatic spurious_resp();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand128();
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        check_quiet("spurious1");
        @(posedge clk); #1;
        check_quiet("spurious2");
        check_eq("spurious_irdata", bus.icache_rdata, exp_ir);
        check_eq("spurious_drdata", bus.dcache_rdata, exp_dr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.icache_read    = 1'b0;
        bus.icache_address = '0;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_address = '0;
        bus.dcache_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
        last_d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_addr", bus.pmem_address, 16'h0);
        check_eq("reset_wdata", bus.pmem_wdata, 128'h0);
        check_eq("reset_irdata", bus.icache_rdata, 128'h0);
        check_eq("reset_drdata", bus.dcache_rdata, 128'h0);
        reset = 1'b0;

        // I-cache fill, fixed 5-cycle memory latency.
        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1236;
        last_d = 1'b0;
        run_txn(1'b1, 1'b0, 16'h1236, '0, 5, {16{8'hA5}});

        // D-cache write-back.
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 16'h4008;
        bus.dcache_wdata   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        last_d = 1'b1;
        run_txn(1'b0, 1'b1, 16'h4008, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 3,
                rand128());

        // Contention, then a D-only grant followed by contention again.
        scenario(1'b1, 2'b01, 16'h0100, 16'h2000, rand128());
        scenario(1'b0, 2'b01, 16'h0000, 16'h3010, rand128());
        scenario(1'b1, 2'b01, 16'h0100, 16'h2000, rand128());

        spurious_resp();
        scenario(1'b0, 2'b11, 16'h0000, 16'h5abc, rand128());

        // Reset two cycles into a D-cache fill.
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 16'h7777;
        @(posedge clk); #1;
        check_eq("pre_reset_read1", bus.pmem_read, 1'b1);
        @(posedge clk); #1;
        check_eq("pre_reset_read2", bus.pmem_read, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset           = 1'b0;
        bus.dcache_read = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
        last_d = 1'b0;
        check_quiet("mid_reset");
        check_eq("mid_reset_drdata", bus.dcache_rdata, 128'h0);
        @(posedge clk); #1;
        check_quiet("post_reset");
        scenario(1'b1, 2'b00, 16'hbeef, 16'h0000, '0);

        for (int it = 0; it < 60; it++) begin
            logic       want_i;
            logic [1:0] dkind;
            want_i = 1'($urandom_range(0, 1));
            dkind  = 2'($urandom_range(0, 3));
            if (!want_i && dkind == 2'b00) begin
                spurious_resp();
            end else begin
                scenario(want_i, dkind, 16'($urandom()), 16'($urandom()), rand128());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
